// File: rtl/mc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mc_scheduler
//  Description : Run-level scheduler for the Monte-Carlo option-pricing
//                engine. Dispatches incoming paths round-robin to free MC
//                cores, collects one payoff per path, accumulates them and
//                reports the averaged price at the end of each run.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_scheduler #(
    parameter int CORE_NUM   = 4,
    parameter int DW         = 12,
    parameter int LOG2_PATHS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DW-1:0]          K,
    input  logic                   path_valid,
    output logic                   path_ready,
    input  logic [DW-1:0]          path,
    input  logic [CORE_NUM-1:0]    core_ready,
    output logic [CORE_NUM-1:0]    core_path_valid,
    output logic [DW-1:0]          core_path,
    output logic [DW-1:0]          core_K,
    input  logic [CORE_NUM-1:0]    core_res_valid,
    input  logic [CORE_NUM*DW-1:0] core_res,
    output logic [CORE_NUM-1:0]    core_res_ack,
    output logic [DW-1:0]          price,
    output logic                   done,
    output logic                   busy
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int PW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;   // pointer width
    localparam int CW = LOG2_PATHS + 1;                          // path counters
    localparam int AW = DW + LOG2_PATHS;                         // accumulator

    // Run length N and N-1 expressed at counter width.
    localparam logic [CW-1:0] N_CNT  = {1'b1, {LOG2_PATHS{1'b0}}};
    localparam logic [CW-1:0] N_LAST = {1'b0, {LOG2_PATHS{1'b1}}};
    localparam logic [PW-1:0] PTR_MAX = PW'(CORE_NUM - 1);

    // Run state machine encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [DW-1:0]       strike;
    logic [DW-1:0]       path_q;
    logic [DW-1:0]       price_q;
    logic [AW-1:0]       acc;
    logic [CW-1:0]       disp_cnt;
    logic [CW-1:0]       res_cnt;
    logic [PW-1:0]       disp_ptr;
    logic [PW-1:0]       res_ptr;
    // Core strobed last cycle; its core_ready is still the stale pre-strobe value.
    logic [CORE_NUM-1:0] pending;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [CORE_NUM-1:0] eligible;
    logic [CORE_NUM-1:0] sel_oh;
    logic [CORE_NUM-1:0] rsel_oh;
    logic [PW-1:0]       sel;
    logic [PW-1:0]       rsel;
    logic [PW-1:0]       sel_inc;
    logic [PW-1:0]       rsel_inc;
    logic                sel_found;
    logic                rsel_found;
    logic [DW-1:0]       payoff;
    logic [AW-1:0]       acc_sum;
    logic                accept;
    logic                xfer;
    logic                collect_en;
    logic                ack_fire;
    logic                last_ack;
    logic                last_disp;

    assign eligible   = core_ready & ~pending;
    assign accept     = (state == S_IDLE) && start;
    assign xfer       = path_valid && path_ready;
    assign collect_en = ((state == S_RUN) || (state == S_DRAIN)) && (res_cnt < N_CNT);
    assign ack_fire   = collect_en && rsel_found;
    assign last_ack   = ack_fire && (res_cnt == N_LAST);
    assign last_disp  = xfer && (disp_cnt == N_LAST);

    assign sel_inc    = (sel  == PTR_MAX) ? '0 : sel  + 1'b1;
    assign rsel_inc   = (rsel == PTR_MAX) ? '0 : rsel + 1'b1;

    // Payoffs are unsigned; zero-extend into the accumulator.
    assign acc_sum    = acc + {{LOG2_PATHS{1'b0}}, payoff};

    assign core_res_ack    = collect_en ? rsel_oh : '0;
    assign core_path_valid = pending;
    assign core_path       = path_q;
    assign core_K          = strike;
    assign price           = price_q;

    // Dispatch pick: first eligible core at or above disp_ptr, else lowest below it.
    always_comb begin
        sel       = '0;
        sel_oh    = '0;
        sel_found = 1'b0;
        for (int i = 0; i < CORE_NUM; i++) begin
            if (!sel_found && eligible[i] && (PW'(i) >= disp_ptr)) begin
                sel_found = 1'b1;
                sel       = PW'(i);
                sel_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < CORE_NUM; i++) begin
            if (!sel_found && eligible[i]) begin
                sel_found = 1'b1;
                sel       = PW'(i);
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Collection pick: same rotating priority over core_res_valid from res_ptr.
    always_comb begin
        rsel       = '0;
        rsel_oh    = '0;
        rsel_found = 1'b0;
        for (int i = 0; i < CORE_NUM; i++) begin
            if (!rsel_found && core_res_valid[i] && (PW'(i) >= res_ptr)) begin
                rsel_found = 1'b1;
                rsel       = PW'(i);
                rsel_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < CORE_NUM; i++) begin
            if (!rsel_found && core_res_valid[i]) begin
                rsel_found = 1'b1;
                rsel       = PW'(i);
                rsel_oh[i] = 1'b1;
            end
        end
    end

    // Payoff mux driven by the one-hot collection pick.
    always_comb begin
        payoff = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            if (rsel_oh[i]) begin
                payoff = core_res[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; finishing collection takes priority over any other move.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_ack) begin
                    state_nxt = S_DONE;
                end else if (last_disp) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_ack) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; path_ready never looks at path_valid.
    always_comb begin
        path_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_RUN: begin
                busy       = 1'b1;
                path_ready = (disp_cnt < N_CNT) && (eligible != '0);
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Strike latch and dispatch side: path register, strobe/pending, pointer, count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strike   <= '0;
            path_q   <= '0;
            pending  <= '0;
            disp_ptr <= '0;
            disp_cnt <= '0;
        end else begin
            pending <= xfer ? sel_oh : '0;
            if (accept) begin
                strike   <= K;
                disp_ptr <= '0;
                disp_cnt <= '0;
            end
            if (xfer) begin
                path_q   <= path;
                disp_ptr <= sel_inc;
                disp_cnt <= disp_cnt + 1'b1;
            end
        end
    end

    // Collection side: accumulate acked payoffs and publish the average on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            res_ptr <= '0;
            res_cnt <= '0;
            price_q <= '0;
        end else begin
            if (accept) begin
                acc     <= '0;
                res_ptr <= '0;
                res_cnt <= '0;
            end
            if (ack_fire) begin
                acc     <= acc_sum;
                res_ptr <= rsel_inc;
                res_cnt <= res_cnt + 1'b1;
                if (last_ack) begin
                    price_q <= acc_sum[AW-1:LOG2_PATHS];
                end
            end
        end
    end

endmodule
`default_nettype wire
